// File: rtl/rf_operand_stage.sv
// Register file with write-first bypass and operand latches for the FU inputs.
// It also holds the N/Z status flags captured from the FU.
module rf_operand_stage #(
   parameter  int W     = 16,
   parameter  int NREGS = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] aa,
   input  logic [AW-1:0] ba,
   input  logic          op_en,
   input  logic          mb,
   input  logic [W-1:0]  const_in,
   input  logic          rw,
   input  logic [AW-1:0] da,
   input  logic          md,
   input  logic [W-1:0]  f_in,
   input  logic [W-1:0]  data_in,
   input  logic          flag_ld,
   input  logic [1:0]    nz_in,
   output logic [W-1:0]  a_out,
   output logic [W-1:0]  b_out,
   output logic [W-1:0]  data_out,
   output logic          n_flag,
   output logic          z_flag
);

   logic [W-1:0] regs_q [NREGS];
   logic [W-1:0] regs_d [NREGS];
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [W-1:0] st_q, st_d;
   logic         n_q, n_d;
   logic         z_q, z_d;

   logic [W-1:0] wdata;
   logic [W-1:0] rd_a;
   logic [W-1:0] rd_b;

   always_comb begin
      wdata = md ? data_in : f_in;
      // Same-cycle write is forwarded so dependent ops need no stall
      rd_a  = (rw && (da == aa)) ? wdata : regs_q[aa];
      rd_b  = (rw && (da == ba)) ? wdata : regs_q[ba];

      regs_d = regs_q;
      if (rw) begin
         regs_d[da] = wdata;
      end

      a_d  = a_q;
      b_d  = b_q;
      st_d = st_q;
      if (op_en) begin
         a_d  = rd_a;
         b_d  = mb ? const_in : rd_b;
         st_d = rd_b;
      end

      n_d = n_q;
      z_d = z_q;
      if (flag_ld) begin
         n_d = nz_in[0];
         z_d = nz_in[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
         a_q    <= '0;
         b_q    <= '0;
         st_q   <= '0;
         n_q    <= 1'b0;
         z_q    <= 1'b0;
      end else begin
         regs_q <= regs_d;
         a_q    <= a_d;
         b_q    <= b_d;
         st_q   <= st_d;
         n_q    <= n_d;
         z_q    <= z_d;
      end
   end

   assign a_out    = a_q;
   assign b_out    = b_q;
   assign data_out = st_q;
   assign n_flag   = n_q;
   assign z_flag   = z_q;

endmodule

// File: tb/tb_rf_operand_stage.sv
// Directed bench for rf_operand_stage: reset, write/read, bypass, MUX B,
// flags and mid-sequence reset, each with hand-computed expectations.
module tb_rf_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  aa, ba, da;
   logic        op_en, mb, rw, md, flag_ld;
   logic [15:0] const_in, f_in, data_in;
   logic [1:0]  nz_in;
   logic [15:0] a_out, b_out, data_out;
   logic        n_flag, z_flag;

   int checks   = 0;
   int failures = 0;

   rf_operand_stage #(.W(16), .NREGS(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .aa       (aa),
      .ba       (ba),
      .op_en    (op_en),
      .mb       (mb),
      .const_in (const_in),
      .rw       (rw),
      .da       (da),
      .md       (md),
      .f_in     (f_in),
      .data_in  (data_in),
      .flag_ld  (flag_ld),
      .nz_in    (nz_in),
      .a_out    (a_out),
      .b_out    (b_out),
      .data_out (data_out),
      .n_flag   (n_flag),
      .z_flag   (z_flag)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 0; rw = 0; op_en = 0; flag_ld = 0; mb = 0; md = 0;
      aa = 0; ba = 0; da = 0;
      const_in = 0; f_in = 0; data_in = 0; nz_in = 0;
   endtask

   initial begin
      idle();
      f_in = 16'h7777; data_in = 16'h8888;

      // 1 Reset
      rst = 1; rw = 1; op_en = 1; flag_ld = 1; nz_in = 2'b11;
      tick();
      idle();
      chk("rst_a", a_out, 16'h0000);
      chk("rst_b", b_out, 16'h0000);
      chk("rst_st", data_out, 16'h0000);
      chk("rst_n", {15'd0, n_flag}, 16'h0000);
      chk("rst_z", {15'd0, z_flag}, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         aa = 3'(i); ba = 3'(7 - i); op_en = 1;
         tick();
         chk("rst_rd_a", a_out, 16'h0000);
         chk("rst_rd_b", b_out, 16'h0000);
      end
      idle();

      // 2 Write then read
      rw = 1; da = 3; md = 1; data_in = 16'hA5A5; f_in = 16'h1111;
      tick();
      idle();
      aa = 3; ba = 0; op_en = 1;
      tick();
      chk("wr_a", a_out, 16'hA5A5);
      chk("wr_b", b_out, 16'h0000);
      chk("wr_st", data_out, 16'h0000);
      idle();
      aa = 0; ba = 0;
      tick();
      chk("hold_a", a_out, 16'hA5A5);

      // 3 Bypass, aa==ba==da, md=0 selects f_in
      rw = 1; da = 2; md = 0; f_in = 16'h1234; data_in = 16'hDEAD;
      aa = 2; ba = 2; mb = 0; op_en = 1;
      tick();
      chk("byp_a", a_out, 16'h1234);
      chk("byp_b", b_out, 16'h1234);
      chk("byp_st", data_out, 16'h1234);
      idle();
      aa = 2; ba = 3; op_en = 1;
      tick();
      chk("rd2_a", a_out, 16'h1234);
      chk("rd3_b", b_out, 16'hA5A5);

      // 4 Constant operand
      idle();
      rw = 1; da = 5; md = 1; data_in = 16'hFFFF;
      tick();
      idle();
      aa = 3; ba = 5; mb = 1; const_in = 16'h0007; op_en = 1;
      tick();
      chk("const_a", a_out, 16'hA5A5);
      chk("const_b", b_out, 16'h0007);
      chk("const_st", data_out, 16'hFFFF);

      // mb=1 with write to ba, plus simultaneous flag load
      idle();
      rw = 1; da = 6; md = 0; f_in = 16'h5A5A;
      aa = 6; ba = 6; mb = 1; const_in = 16'h0042; op_en = 1;
      flag_ld = 1; nz_in = 2'b01;
      tick();
      chk("mbw_a", a_out, 16'h5A5A);
      chk("mbw_b", b_out, 16'h0042);
      chk("mbw_st", data_out, 16'h5A5A);
      chk("mbw_n", {15'd0, n_flag}, 16'h0001);
      chk("mbw_z", {15'd0, z_flag}, 16'h0000);

      // 5 Flags load and hold
      idle();
      flag_ld = 1; nz_in = 2'b10;
      tick();
      chk("fl_n", {15'd0, n_flag}, 16'h0000);
      chk("fl_z", {15'd0, z_flag}, 16'h0001);
      flag_ld = 0; nz_in = 2'b01;
      tick();
      chk("flh_n", {15'd0, n_flag}, 16'h0000);
      chk("flh_z", {15'd0, z_flag}, 16'h0001);

      // R0 is an ordinary writable register
      idle();
      rw = 1; da = 0; md = 1; data_in = 16'h0F0F;
      tick();
      idle();
      aa = 0; ba = 6; op_en = 1;
      tick();
      chk("r0_a", a_out, 16'h0F0F);
      chk("r6_b", b_out, 16'h5A5A);

      // 6 Reset mid-operation discards write and latch
      idle();
      rst = 1; rw = 1; da = 4; md = 1; data_in = 16'hBEEF;
      aa = 4; ba = 4; op_en = 1; flag_ld = 1; nz_in = 2'b11;
      tick();
      idle();
      chk("mrst_a", a_out, 16'h0000);
      chk("mrst_st", data_out, 16'h0000);
      chk("mrst_z", {15'd0, z_flag}, 16'h0000);
      aa = 4; ba = 3; op_en = 1;
      tick();
      chk("mrst_r4", a_out, 16'h0000);
      chk("mrst_r3", b_out, 16'h0000);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
